// File: rtl/fft4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft4_pkg : shared types and helpers for the 4-point FFT front end |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package fft4_pkg;

  localparam int N_POINTS = 4;
  localparam int CPLX_W   = 8;
  localparam int MAX_W    = 32;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  function automatic logic [1:0] bitrev2(input logic [1:0] idx);
    return {idx[0], idx[1]};
  endfunction

  // Maps the most negative w-bit value onto its symmetric neighbour.
  function automatic logic signed [MAX_W-1:0] sym_clip(input logic signed [MAX_W-1:0] x,
                                                       input int unsigned w);
    logic signed [MAX_W-1:0] most_neg;
    most_neg = {MAX_W{1'b1}} << (w - 1);
    return (x == most_neg) ? x + 32'sd1 : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft4_frame_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft4_frame_bank : one frame of N_POINTS complex registers with    |
// |                   slot-addressed write and parallel read          |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module fft4_frame_bank
  import fft4_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [1:0]                     slot_i,
  input  logic [DATA_WIDTH-1:0]          re_i,
  input  logic [DATA_WIDTH-1:0]          im_i,
  output logic [N_POINTS*DATA_WIDTH-1:0] rd_re_o,
  output logic [N_POINTS*DATA_WIDTH-1:0] rd_im_o
);

  for (genvar k = 0; k < N_POINTS; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] re_q;
    logic [DATA_WIDTH-1:0] im_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        re_q <= '0;
        im_q <= '0;
      end else if (we_i && (slot_i == 2'(k))) begin
        re_q <= re_i;
        im_q <= im_i;
      end
    end

    assign rd_re_o[k*DATA_WIDTH +: DATA_WIDTH] = re_q;
    assign rd_im_o[k*DATA_WIDTH +: DATA_WIDTH] = im_q;
  end

endmodule
`default_nettype wire

// File: rtl/fft4_in_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft4_in_buf : bit-reversing ping-pong input frame buffer          |
// |               Option macro: FFT4_IN_SAT_EN (symmetric saturation) |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module fft4_in_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int N_POINTS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_real,
  input  logic [DATA_WIDTH-1:0]          in_imag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_POINTS*DATA_WIDTH-1:0] out_real,
  output logic [N_POINTS*DATA_WIDTH-1:0] out_imag
);
  import fft4_pkg::*;

  logic                           wr_bank_q, wr_bank_d;
  logic                           rd_bank_q, rd_bank_d;
  logic [1:0]                     wr_idx_q, wr_idx_d;
  logic [1:0]                     bank_full_q, bank_full_d;
  logic                           w_accept, w_consume, w_wrap;
  logic [DATA_WIDTH-1:0]          w_st_re, w_st_im;
  logic [N_POINTS*DATA_WIDTH-1:0] w_b_re [2];
  logic [N_POINTS*DATA_WIDTH-1:0] w_b_im [2];

  assign in_ready  = !bank_full_q[wr_bank_q];
  assign out_valid = bank_full_q[rd_bank_q];
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;
  assign w_wrap    = w_accept && (wr_idx_q == 2'd3);

`ifdef FFT4_IN_SAT_EN
  assign w_st_re = DATA_WIDTH'(sym_clip(MAX_W'($signed(in_real)), DATA_WIDTH));
  assign w_st_im = DATA_WIDTH'(sym_clip(MAX_W'($signed(in_imag)), DATA_WIDTH));
`else
  assign w_st_re = in_real;
  assign w_st_im = in_imag;
`endif

  // A filling bank is never full and a draining bank always is, so set/clear never collide.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    if (w_accept) begin
      wr_idx_d = wr_idx_q + 2'd1;
    end
    if (w_wrap) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = !wr_bank_q;
    end
    if (w_consume) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = !rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q    <= 2'd0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft4_frame_bank #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (w_accept && (wr_bank_q == 1'(b))),
      .slot_i  (bitrev2(wr_idx_q)),
      .re_i    (w_st_re),
      .im_i    (w_st_im),
      .rd_re_o (w_b_re[b]),
      .rd_im_o (w_b_im[b])
    );
  end

  assign out_real = rd_bank_q ? w_b_re[1] : w_b_re[0];
  assign out_imag = rd_bank_q ? w_b_im[1] : w_b_im[0];

endmodule
`default_nettype wire
